// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the program-counter sequencer.
package pc_seq_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALTED} state_t;

  typedef enum logic [2:0] {
    SEL_HOLD, SEL_SEQ, SEL_BRANCH, SEL_JUMP, SEL_JR, SEL_VEC, SEL_EPC
  } npc_sel_t;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0100;
  localparam int unsigned VEC_STRIDE_DEF = 4;
endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: valid flag, binary index, one-hot grant.
module irq_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot
);
  assign valid  = |req;
  // two's-complement trick isolates the lowest set bit
  assign onehot = req & (~req + N'(1));

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) idx = IDX_W'(i);
  end
endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: run/halt control, stall hold, vectored IRQ entry with EPC, ERET.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          IRQ_N      = 4,
  parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
  parameter int unsigned VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_go,
  input  logic             in_halt,
  input  logic             in_stall,
  input  logic             in_branch_taken,
  input  logic [31:0]      in_extended,
  input  logic             in_jump,
  input  logic [25:0]      in_jump_target,
  input  logic             in_jr,
  input  logic [31:0]      in_jr_target,
  input  logic             in_eret,
  input  logic             in_irq_enable,
  input  logic [IRQ_N-1:0] in_irq_req,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_pc_plus1,
  output logic [31:0]      out_epc,
  output logic [IRQ_N-1:0] out_irq_ack,
  output logic             out_in_isr,
  output logic             out_halted
);
  localparam int IDX_W = (IRQ_N > 1) ? $clog2(IRQ_N) : 1;

  state_t           state, state_d;
  npc_sel_t         sel, normal_sel;
  logic [31:0]      pc, epc, seq, branch, jump, vec, next_pc, normal_npc;
  logic             in_isr, halted, go_q, go_rise, irq_ok, take_irq;
  logic [IRQ_N-1:0] irq_ack, irq_onehot;
  logic             irq_valid;
  logic [IDX_W-1:0] irq_idx;

  irq_prio_enc #(.N(IRQ_N), .IDX_W(IDX_W)) u_enc (
    .req(in_irq_req), .valid(irq_valid), .idx(irq_idx), .onehot(irq_onehot)
  );

  assign seq     = pc + 32'd1;
  assign branch  = pc + 32'd1 + in_extended;
  assign jump    = {seq[31:26], in_jump_target};
  assign vec     = VEC_BASE + VEC_STRIDE * 32'(irq_idx);
  assign go_rise = in_go & ~go_q;
  assign irq_ok  = irq_valid & in_irq_enable & ~in_isr;

  function automatic logic [31:0] pick(input npc_sel_t s);
    case (s)
      SEL_SEQ:    pick = seq;
      SEL_BRANCH: pick = branch;
      SEL_JUMP:   pick = jump;
      SEL_JR:     pick = in_jr_target;
      SEL_VEC:    pick = vec;
      SEL_EPC:    pick = epc;
      default:    pick = pc;
    endcase
  endfunction

  // The instruction's own next PC, ignoring stall/irq/eret; this is what EPC saves.
  always_comb begin
    normal_sel = SEL_SEQ;
    if      (in_halt)         normal_sel = SEL_SEQ;
    else if (in_jr)           normal_sel = SEL_JR;
    else if (in_jump)         normal_sel = SEL_JUMP;
    else if (in_branch_taken) normal_sel = SEL_BRANCH;
  end

  always_comb begin
    sel      = SEL_HOLD;
    state_d  = state;
    take_irq = 1'b0;
    case (state)
      ST_IDLE: if (go_rise) state_d = ST_RUN;
      ST_RUN: if (!in_stall) begin
        if (irq_ok) begin
          sel      = SEL_VEC;
          take_irq = 1'b1;
        end else if (in_eret && in_isr) sel = SEL_EPC;
        else if (in_eret)               sel = SEL_SEQ;
        else begin
          sel = normal_sel;
          if (in_halt) state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (irq_ok) begin
          sel      = SEL_VEC;
          take_irq = 1'b1;
          state_d  = ST_RUN;
        end else if (go_rise) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
    next_pc    = pick(sel);
    normal_npc = pick(normal_sel);
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state   <= ST_IDLE;
      pc      <= RESET_PC;
      epc     <= '0;
      irq_ack <= '0;
      in_isr  <= 1'b0;
      halted  <= 1'b1;
      go_q    <= 1'b0;
    end else begin
      state   <= state_d;
      pc      <= next_pc;
      halted  <= (state_d != ST_RUN);
      go_q    <= in_go;
      irq_ack <= take_irq ? irq_onehot : '0;
      if (take_irq) begin
        // a sleeping core has already advanced past its HALT
        epc    <= (state == ST_HALTED) ? pc : normal_npc;
        in_isr <= 1'b1;
      end else if (sel == SEL_EPC) begin
        in_isr <= 1'b0;
      end
    end
  end

  assign out_pc       = pc;
  assign out_pc_plus1 = seq;
  assign out_epc      = epc;
  assign out_irq_ack  = irq_ack;
  assign out_in_isr   = in_isr;
  assign out_halted   = halted;
endmodule
